// File: rtl/idecode_pkg.sv
// idecode_pkg: opcode classes, register constants and ARM field layout for the decode queue
package idecode_pkg;
   typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10} op_t;
   localparam logic [3:0] REG_PC = 4'hF;
   typedef struct packed {
      logic [3:0]  cond;
      op_t         op;
      logic [5:0]  funct;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [11:0] src2;
   } instr_fields_t;
endpackage

// File: rtl/idq_predecode.sv
// idq_predecode: extracts Rd, cond and register-file read addresses from one instruction
module idq_predecode
   import idecode_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  rd,
   output logic [3:0]  cond,
   output logic [3:0]  ra1,
   output logic [3:0]  ra2
);
   instr_fields_t f;
   assign f = instr_fields_t'(instr);
   assign rd = f.rd;
   assign cond = f.cond;
   // branches read PC as base; stores need Rd as the second read port
   assign ra1 = (f.op == OP_BR) ? REG_PC : f.rn;
   assign ra2 = (f.op == OP_MEM) ? f.rd : f.src2[3:0];
endmodule

// File: rtl/idecode_queue.sv
// idecode_queue: fetch-to-decode valid/ready FIFO with flush and head pre-decode
module idecode_queue
   import idecode_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INSTR_W-1:0]       in_instr,
   input  logic [PC_W-1:0]          in_pcplus8,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [PC_W-1:0]          out_pcplus8,
   output logic [3:0]               out_rd,
   output logic [3:0]               out_cond,
   output logic [3:0]               out_ra1,
   output logic [3:0]               out_ra2,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [PC_W-1:0]    mem_pc [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               push, pop;
   // pointers carry one extra wrap bit so full and empty are distinguishable
   assign count = wr_ptr - rd_ptr;
   assign out_valid = wr_ptr != rd_ptr;
   assign in_ready = !(wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push = in_valid && in_ready;
   assign pop = out_valid && out_ready;
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr[AW-1:0]] <= in_instr;
            mem_pc[wr_ptr[AW-1:0]] <= in_pcplus8;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   assign out_instr = mem_instr[rd_ptr[AW-1:0]];
   assign out_pcplus8 = mem_pc[rd_ptr[AW-1:0]];
   idq_predecode u_predecode (
      .instr(out_instr),
      .rd(out_rd),
      .cond(out_cond),
      .ra1(out_ra1),
      .ra2(out_ra2)
   );
endmodule
